// File: rtl/riscv_pkg.sv
// Shared RV32I constants: opcodes, one-hot instruction indices, decoded-entry struct.
package riscv_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_INSTR = 37;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam int INSTR_ADD   = 0;
  localparam int INSTR_SUB   = 1;
  localparam int INSTR_XOR   = 2;
  localparam int INSTR_OR    = 3;
  localparam int INSTR_AND   = 4;
  localparam int INSTR_SLL   = 5;
  localparam int INSTR_SRL   = 6;
  localparam int INSTR_SRA   = 7;
  localparam int INSTR_SLT   = 8;
  localparam int INSTR_SLTU  = 9;
  localparam int INSTR_ADDI  = 10;
  localparam int INSTR_XORI  = 11;
  localparam int INSTR_ORI   = 12;
  localparam int INSTR_ANDI  = 13;
  localparam int INSTR_SLLI  = 14;
  localparam int INSTR_SRLI  = 15;
  localparam int INSTR_SRAI  = 16;
  localparam int INSTR_SLTI  = 17;
  localparam int INSTR_SLTIU = 18;
  localparam int INSTR_LB    = 19;
  localparam int INSTR_LH    = 20;
  localparam int INSTR_LW    = 21;
  localparam int INSTR_LBU   = 22;
  localparam int INSTR_LHU   = 23;
  localparam int INSTR_SB    = 24;
  localparam int INSTR_SH    = 25;
  localparam int INSTR_SW    = 26;
  localparam int INSTR_BEQ   = 27;
  localparam int INSTR_BNE   = 28;
  localparam int INSTR_BLT   = 29;
  localparam int INSTR_BGE   = 30;
  localparam int INSTR_BLTU  = 31;
  localparam int INSTR_BGEU  = 32;
  localparam int INSTR_JAL   = 33;
  localparam int INSTR_JALR  = 34;
  localparam int INSTR_LUI   = 35;
  localparam int INSTR_AUIPC = 36;

  typedef struct packed {
    logic [NUM_INSTR-1:0] instructions;
    logic [XLEN-1:0]      imm;
    logic [4:0]           rs1_addr;
    logic [4:0]           rs2_addr;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      pc;
    logic                 illegal;
  } dec_t;
endpackage

// File: rtl/imm_gen.sv
// Combinational immediate extraction; format chosen from the opcode.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);
  logic [6:0] op;
  logic [2:0] f3;

  assign op = instr[6:0];
  assign f3 = instr[14:12];

  always_comb begin
    imm = '0;
    case (op)
      OP_IMM: begin
        // shift-immediates carry shamt, not a signed immediate
        if (f3 == 3'b001 || f3 == 3'b101) imm = {{(XLEN-5){1'b0}}, instr[24:20]};
        else                              imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      LOAD, JALR: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      STORE:      imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      BRANCH:     imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      JAL:        imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      LUI, AUIPC: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      default:    imm = '0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-hot decode + single output register with valid/ready and flush.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_INSTR-1:0] instructions,
  output logic [XLEN-1:0]      imm,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output logic [4:0]           rd_addr,
  output logic [XLEN-1:0]      out_pc,
  output logic                 illegal
);
  logic [6:0]           op;
  logic [2:0]           f3;
  logic [6:0]           f7;
  logic [NUM_INSTR-1:0] oh;
  logic [XLEN-1:0]      imm_raw;
  logic                 f7_zero, f7_alt;
  dec_t                 dec_d, dec_q;
  logic                 vld_q;

  assign op      = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  imm_gen #(.XLEN(XLEN)) u_imm (.instr(in_instr), .imm(imm_raw));

  always_comb begin
    oh = '0;
    case (op)
      OP: case (f3)
        3'b000: begin oh[INSTR_ADD] = f7_zero; oh[INSTR_SUB] = f7_alt; end
        3'b001: oh[INSTR_SLL]  = f7_zero;
        3'b010: oh[INSTR_SLT]  = f7_zero;
        3'b011: oh[INSTR_SLTU] = f7_zero;
        3'b100: oh[INSTR_XOR]  = f7_zero;
        3'b101: begin oh[INSTR_SRL] = f7_zero; oh[INSTR_SRA] = f7_alt; end
        3'b110: oh[INSTR_OR]   = f7_zero;
        default: oh[INSTR_AND] = f7_zero;
      endcase
      OP_IMM: case (f3)
        3'b000: oh[INSTR_ADDI]  = 1'b1;
        3'b001: oh[INSTR_SLLI]  = f7_zero;
        3'b010: oh[INSTR_SLTI]  = 1'b1;
        3'b011: oh[INSTR_SLTIU] = 1'b1;
        3'b100: oh[INSTR_XORI]  = 1'b1;
        3'b101: begin oh[INSTR_SRLI] = f7_zero; oh[INSTR_SRAI] = f7_alt; end
        3'b110: oh[INSTR_ORI]   = 1'b1;
        default: oh[INSTR_ANDI] = 1'b1;
      endcase
      LOAD: case (f3)
        3'b000: oh[INSTR_LB]  = 1'b1;
        3'b001: oh[INSTR_LH]  = 1'b1;
        3'b010: oh[INSTR_LW]  = 1'b1;
        3'b100: oh[INSTR_LBU] = 1'b1;
        3'b101: oh[INSTR_LHU] = 1'b1;
        default: ;
      endcase
      STORE: case (f3)
        3'b000: oh[INSTR_SB] = 1'b1;
        3'b001: oh[INSTR_SH] = 1'b1;
        3'b010: oh[INSTR_SW] = 1'b1;
        default: ;
      endcase
      BRANCH: case (f3)
        3'b000: oh[INSTR_BEQ]  = 1'b1;
        3'b001: oh[INSTR_BNE]  = 1'b1;
        3'b100: oh[INSTR_BLT]  = 1'b1;
        3'b101: oh[INSTR_BGE]  = 1'b1;
        3'b110: oh[INSTR_BLTU] = 1'b1;
        3'b111: oh[INSTR_BGEU] = 1'b1;
        default: ;
      endcase
      JAL:   oh[INSTR_JAL]   = 1'b1;
      JALR:  oh[INSTR_JALR]  = (f3 == 3'b000);
      LUI:   oh[INSTR_LUI]   = 1'b1;
      AUIPC: oh[INSTR_AUIPC] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    dec_d              = '0;
    dec_d.instructions = oh;
    dec_d.illegal      = ~(|oh);
    dec_d.imm          = (|oh) ? imm_raw : '0;
    dec_d.rs1_addr     = in_instr[19:15];
    dec_d.rs2_addr     = in_instr[24:20];
    dec_d.rd_addr      = in_instr[11:7];
    dec_d.pc           = in_pc;
  end

  assign in_ready = !vld_q || out_ready;

  // flush wins over both accept and consume; data holds when valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      dec_q <= '0;
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      vld_q <= 1'b1;
      dec_q <= dec_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid    = vld_q;
  assign instructions = dec_q.instructions;
  assign imm          = dec_q.imm;
  assign rs1_addr     = dec_q.rs1_addr;
  assign rs2_addr     = dec_q.rs2_addr;
  assign rd_addr      = dec_q.rd_addr;
  assign out_pc       = dec_q.pc;
  assign illegal      = dec_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed vector bench for decode_stage: decode table plus handshake/flush/reset sequences.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0] in_instr, in_pc, imm, out_pc;
  logic [36:0] instructions;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .instructions(instructions), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .out_pc(out_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [36:0] ins;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        il;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive between edges, then sample 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [36:0] held_ins;
    logic [31:0] held_pc;

    vecs[0]  = '{32'h002081B3, 37'h1,          32'h0,        5'd3,  5'd1,  5'd2,  1'b0};
    vecs[1]  = '{32'hFFF00093, 37'h400,        32'hFFFFFFFF, 5'd1,  5'd0,  5'd31, 1'b0};
    vecs[2]  = '{32'h40335293, 37'h10000,      32'h3,        5'd5,  5'd6,  5'd3,  1'b0};
    vecs[3]  = '{32'hFE208CE3, 37'h8000000,    32'hFFFFFFF8, 5'd25, 5'd1,  5'd2,  1'b0};
    vecs[4]  = '{32'hFFFFFFFF, 37'h0,          32'h0,        5'd31, 5'd31, 5'd31, 1'b1};
    vecs[5]  = '{32'h407302B3, 37'h2,          32'h0,        5'd5,  5'd6,  5'd7,  1'b0};
    vecs[6]  = '{32'h0020A623, 37'h4000000,    32'hC,        5'd12, 5'd1,  5'd2,  1'b0};
    vecs[7]  = '{32'hFFDFF0EF, 37'h200000000,  32'hFFFFFFFC, 5'd1,  5'd31, 5'd29, 1'b0};
    vecs[8]  = '{32'h12345537, 37'h800000000,  32'h12345000, 5'd10, 5'd8,  5'd3,  1'b0};
    vecs[9]  = '{32'hFF012203, 37'h200000,     32'hFFFFFFF0, 5'd4,  5'd2,  5'd16, 1'b0};
    vecs[10] = '{32'h4020C1B3, 37'h0,          32'h0,        5'd3,  5'd1,  5'd2,  1'b1};
    vecs[11] = '{32'h40311293, 37'h0,          32'h0,        5'd5,  5'd2,  5'd3,  1'b1};
    vecs[12] = '{32'hFFFFF397, 37'h1000000000, 32'hFFFFF000, 5'd7,  5'd31, 5'd31, 1'b0};
    vecs[13] = '{32'h00335293, 37'h8000,       32'h3,        5'd5,  5'd6,  5'd3,  1'b0};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_instructions", instructions, 0);
    chk("reset_imm", imm, 0);
    chk("reset_illegal", illegal, 0);
    @(negedge clk); rst = 1'b0;

    // streaming decode table, one instruction per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(i * 4);
      step();
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_ins", i), instructions, vecs[i].ins);
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), rd_addr, vecs[i].rd);
      chk($sformatf("v%0d_rs1", i), rs1_addr, vecs[i].rs1);
      chk($sformatf("v%0d_rs2", i), rs2_addr, vecs[i].rs2);
      chk($sformatf("v%0d_illegal", i), illegal, vecs[i].il);
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
    end

    // consume with no new accept: valid drops, data held
    @(negedge clk); in_valid = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_data_held", instructions, 37'h8000);

    // backpressure: entry holds for 3 cycles while a new instruction waits
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h2000;
    step();
    chk("bp_accept_valid", out_valid, 1);
    @(negedge clk); out_ready = 1'b0; in_instr = 32'hFFF00093; in_pc = 32'h2004;
    #1 chk("bp_in_ready_low", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("bp%0d_valid", c), out_valid, 1);
      chk($sformatf("bp%0d_ins", c), instructions, 37'h1);
      chk($sformatf("bp%0d_pc", c), out_pc, 32'h2000);
      chk($sformatf("bp%0d_in_ready", c), in_ready, 0);
    end
    held_ins = 37'h1; held_pc = 32'h2000;

    // flush while an accept would otherwise happen
    @(negedge clk); out_ready = 1'b1; flush = 1'b1;
    #1 chk("fl_in_ready_high", in_ready, 1);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_not_presented", instructions, held_ins);
    chk("fl_pc_held", out_pc, held_pc);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_stays_empty", out_valid, 0);

    // consume and accept in the same cycle keeps valid high
    @(negedge clk); in_valid = 1'b1; in_instr = 32'h40335293;
    step();
    @(negedge clk); in_instr = 32'hFE208CE3;
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_ins", instructions, 37'h8000000);

    // async reset mid-transfer clears immediately, before any edge
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ins", instructions, 0);
    chk("arst_imm", imm, 0);
    @(negedge clk); rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage of the RV32I core. Accepts a 32-bit instruction word and its PC from fetch, then decodes it into the 37-bit one-hot `instructions` vector consumed by `alu`. It also extracts register addresses and produces a sign-extended `imm`. Output sits in a single pipeline register with valid/ready flow control and flush support.

## Interface
- `XLEN`, 32: data and PC width.
- `NUM_INSTR`, 37: width of the one-hot instruction vector.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  fetch presents a valid instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  raw instruction word.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `flush`  in  1  discard the held entry and the instruction being accepted this cycle.
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  downstream consumes the entry.
- `instructions`  out  37  one-hot op, zero when illegal.
- `imm`  out  XLEN  sign- or zero-extended immediate.
- `rs1_addr`, `rs2_addr`, `rd_addr`  out  5 each  register indices.
- `out_pc`  out  XLEN  PC passthrough.
- `illegal`  out  1  unrecognised encoding.

## Operation
- One-hot bits 0–18:
  - 0–9: add, sub, xor, or, and, sll, srl, sra, slt, sltu.
  - 10–18: addi, xori, ori, andi, slli, srli, srai, slti, sltiu.
- One-hot bits 19–36:
  - 19–23: lb, lh, lw, lbu, lhu.
  - 24–26: sb, sh, sw.
  - 27–32: beq, bne, blt, bge, bltu, bgeu.
  - 33–36: jal, jalr, lui, auipc.
- Decode fields: opcode [6:0], funct3 [14:12], funct7 [31:25].
  - R-type: funct7 must be 0000000, or 0100000 for sub and sra only.
  - Immediate shifts: srai requires funct7=0100000; slli and srli require 0000000.
- Immediate by format:
  - I: sign-extended [31:20].
  - Shifts: {27'b0, [24:20]}.
  - S: sign-extended {[31:25],[11:7]}.
  - B: sign-extended {[31],[7],[30:25],[11:8],0}.
  - J: sign-extended {[31],[19:12],[20],[30:21],0}.
  - U: {[31:12],12'b0}.
  - R-type: 0.
- Register addresses always come from bits [19:15], [24:20] and [11:7], whatever the format.
- Illegal encoding (any opcode/funct combination outside the list above):
  - `illegal`=1, `instructions`=0, `imm`=0.
  - Register fields still pass through.
  - Entry is still handed downstream as valid.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready`.
  - Accept when `in_valid` && `in_ready`: register all decoded outputs, set `out_valid`.
  - Consume without a new accept: clear `out_valid`.
  - Consume and accept in the same cycle: replace the entry, keep `out_valid`=1.
- Flush:
  - `flush`=1 clears `out_valid` next edge.
  - Any instruction accepted in the same cycle is dropped.
  - `flush` has priority over accept.
- Reset: all outputs 0. Reset mid-transfer drops the held entry immediately (asynchronous).

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready`=1.
- Output stability: while `out_valid`=1 and `out_ready`=0, all outputs hold stable.
- `in_ready` is combinational from `out_ready`. There is no combinational path from `in_instr` to any output.
- Data outputs after consume: they keep their last value when `out_valid` falls. Downstream qualifies them with `out_valid`.
- Simultaneous `flush` and `out_ready`: the entry is treated as flushed.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - one-hot bit index constants (INSTR_ADD=0 … INSTR_AUIPC=36), also used by `alu` and later stages;
  - `NUM_INSTR`.
- Sub-module `imm_gen`: combinational, instruction word → `imm`, selecting format from the opcode.
- The one-hot decoder and pipeline register stay in `decode_stage`.

## Test plan
- R-type: 0x002081B3 (add x3,x1,x2) accepted → next cycle:
  - `instructions`=37'h1, rd=3, rs1=1, rs2=2, `imm`=0.
- I-type, negative immediate: 0xFFF00093 (addi x1,x0,-1) → `instructions`=37'h400, `imm`=0xFFFFFFFF, rd=1.
- Shift immediate: 0x40335293 (srai x5,x6,3) → `instructions`=37'h10000, `imm`=3.
- Branch immediate: 0xFE208CE3 (beq x1,x2,-8) → `instructions`=37'h8000000, `imm`=0xFFFFFFF8.
- Illegal encoding: 0xFFFFFFFF → `illegal`=1, `instructions`=0, `out_valid`=1.
- Backpressure, then flush:
  - Hold `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0.
  - Assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, the new instruction is not presented.
